// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - BCD limits and load validation shared by the time-of-day counter
package time_keeper_pkg;

  localparam logic [7:0] SEC_MAX       = 8'h59;
  localparam logic [7:0] MIN_MAX       = 8'h59;
  localparam logic [7:0] HOUR_MAX      = 8'h23;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

  // Both digits of every field must be decimal before the range compare means anything.
  function automatic logic load_valid(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    logic digits_ok;
    digits_ok = (h[7:4] <= BCD_DIGIT_MAX) && (h[3:0] <= BCD_DIGIT_MAX) &&
                (m[7:4] <= BCD_DIGIT_MAX) && (m[3:0] <= BCD_DIGIT_MAX) &&
                (s[7:4] <= BCD_DIGIT_MAX) && (s[3:0] <= BCD_DIGIT_MAX);
    return digits_ok && (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD modulo counter with load and carry out
module bcd2_counter
  import time_keeper_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (inc) begin
      if (q_q == MAX_VAL) begin
        q_d = 8'h00;
      end else if (q_q[3:0] == BCD_DIGIT_MAX) begin
        q_d = {q_q[7:4] + 4'h1, 4'h0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'h1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX_VAL);

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour BCD time-of-day counter with 1 Hz prescaler and validated load
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               sec_tick_q, sec_tick_d;
  logic               day_tick_q, day_tick_d;
  logic               load_err_q, load_err_d;

  logic load_ok;
  logic tick;
  logic inc_ss;
  logic carry_ss, carry_mm, carry_hh;

  // A valid load takes priority over a coincident tick, so the tick is dropped entirely.
  always_comb begin
    load_ok    = load && load_valid(load_hh, load_mm, load_ss);
    tick       = run && (presc_q == PRESC_LAST);
    inc_ss     = tick && !load_ok;
    presc_d    = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end
    sec_tick_d = inc_ss;
    day_tick_d = carry_hh;
    load_err_d = load && !load_ok;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end

  bcd2_counter #(.MAX_VAL(SEC_MAX)) u_sec (
    .clk     (clk),
    .clear_n (clear_n),
    .inc     (inc_ss),
    .ld      (load_ok),
    .ld_val  (load_ss),
    .q       (ss),
    .carry   (carry_ss)
  );

  bcd2_counter #(.MAX_VAL(MIN_MAX)) u_min (
    .clk     (clk),
    .clear_n (clear_n),
    .inc     (carry_ss),
    .ld      (load_ok),
    .ld_val  (load_mm),
    .q       (mm),
    .carry   (carry_mm)
  );

  bcd2_counter #(.MAX_VAL(HOUR_MAX)) u_hour (
    .clk     (clk),
    .clear_n (clear_n),
    .inc     (carry_mm),
    .ld      (load_ok),
    .ld_val  (load_hh),
    .q       (hh),
    .carry   (carry_hh)
  );

  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - vector table plus randomized run against a seconds-of-day reference model
module tb_time_keeper;

  localparam int CLK_DIV = 4;
  localparam int PRESC_W = 3;

  logic       clk = 1'b0;
  logic       clear_n, run, load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh, mm, ss;
  logic       sec_tick, day_tick, load_err;

  always #5 clk = ~clk;

  time_keeper #(.CLK_DIV(CLK_DIV), .PRESC_W(PRESC_W)) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .run      (run),
    .load     (load),
    .load_hh  (load_hh),
    .load_mm  (load_mm),
    .load_ss  (load_ss),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .sec_tick (sec_tick),
    .day_tick (day_tick),
    .load_err (load_err)
  );

  typedef struct {
    logic       clear_n;
    logic       run;
    logic       load;
    logic [7:0] lh, lm, ls;
    int         cycles;
    logic [7:0] eh, em, es;
    logic       est, edt, eerr;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: time as seconds since midnight, prescaler as a plain phase count.
  int   m_secs  = 0;
  int   m_phase = 0;
  logic m_st = 0, m_dt = 0, m_err = 0;

  function automatic int field_val(input logic [7:0] b, input int lim);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (v < lim) ? v : -1;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic vec_t mk(input logic c, input logic r, input logic l,
                              input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                              input int n, input logic [7:0] eh, input logic [7:0] em,
                              input logic [7:0] es, input logic est, input logic edt,
                              input logic eerr);
    vec_t v;
    v.clear_n = c; v.run = r; v.load = l; v.lh = lh; v.lm = lm; v.ls = ls; v.cycles = n;
    v.eh = eh; v.em = em; v.es = es; v.est = est; v.edt = edt; v.eerr = eerr;
    return v;
  endfunction

  task automatic model_update();
    int h, m, s;
    logic tick;
    if (!clear_n) begin
      m_secs = 0; m_phase = 0; m_st = 0; m_dt = 0; m_err = 0;
      return;
    end
    h = field_val(load_hh, 24);
    m = field_val(load_mm, 60);
    s = field_val(load_ss, 60);
    tick = run && (m_phase == CLK_DIV - 1);
    m_st = 0; m_dt = 0; m_err = 0;
    if (load && h >= 0 && m >= 0 && s >= 0) begin
      m_secs  = h * 3600 + m * 60 + s;
      m_phase = 0;
    end else begin
      m_err = load;
      if (run) m_phase = (m_phase + 1) % CLK_DIV;
      if (tick) begin
        m_secs = (m_secs + 1) % 86400;
        m_st   = 1;
        m_dt   = (m_secs == 0);
      end
    end
  endtask

  task automatic step();
    logic [7:0] eh, em, es;
    model_update();
    @(posedge clk);
    #1;
    eh = to_bcd(m_secs / 3600);
    em = to_bcd((m_secs / 60) % 60);
    es = to_bcd(m_secs % 60);
    checks++;
    if ({hh, mm, ss, sec_tick, day_tick, load_err} !== {eh, em, es, m_st, m_dt, m_err}) begin
      errors++;
      $display("FAIL model t=%0t got %h:%h:%h st=%b dt=%b err=%b want %h:%h:%h st=%b dt=%b err=%b",
               $time, hh, mm, ss, sec_tick, day_tick, load_err, eh, em, es, m_st, m_dt, m_err);
    end
  endtask

  initial begin
    // reset with run and a valid load asserted
    vecs.push_back(mk(0,1,1, 8'h23,8'h59,8'h58, 3,  8'h00,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 3,  8'h00,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h01, 1,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 36, 8'h00,8'h00,8'h10, 1,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 200,8'h00,8'h01,8'h00, 1,0,0));
    // midnight rollover
    vecs.push_back(mk(1,1,1, 8'h23,8'h59,8'h58, 1,  8'h23,8'h59,8'h58, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 4,  8'h23,8'h59,8'h59, 1,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 4,  8'h00,8'h00,8'h00, 1,1,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,0));
    // invalid loads keep time and phase
    vecs.push_back(mk(1,1,1, 8'h24,8'h00,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,1));
    vecs.push_back(mk(1,1,1, 8'h00,8'h5A,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,1));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h01, 1,0,0));
    // load coincident with a would-be midnight tick
    vecs.push_back(mk(1,1,1, 8'h23,8'h59,8'h59, 1,  8'h23,8'h59,8'h59, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 3,  8'h23,8'h59,8'h59, 0,0,0));
    vecs.push_back(mk(1,1,1, 8'h12,8'h00,8'h00, 1,  8'h12,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 3,  8'h12,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h12,8'h00,8'h01, 1,0,0));
    // freeze, resume, mid-count reset
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 2,  8'h12,8'h00,8'h01, 0,0,0));
    vecs.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 20, 8'h12,8'h00,8'h01, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h12,8'h00,8'h01, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h12,8'h00,8'h02, 1,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 2,  8'h12,8'h00,8'h02, 0,0,0));
    vecs.push_back(mk(0,1,0, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 3,  8'h00,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h01, 1,0,0));
    // load while stopped still clears the prescaler
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 2,  8'h00,8'h00,8'h01, 0,0,0));
    vecs.push_back(mk(1,0,1, 8'h01,8'h02,8'h03, 1,  8'h01,8'h02,8'h03, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 3,  8'h01,8'h02,8'h03, 0,0,0));
    vecs.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,  8'h01,8'h02,8'h04, 1,0,0));
    // loading 00:00:00 is not a midnight event; bad low nibble rejected
    vecs.push_back(mk(1,1,1, 8'h00,8'h00,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,0));
    vecs.push_back(mk(1,1,1, 8'h1A,8'h00,8'h00, 1,  8'h00,8'h00,8'h00, 0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      clear_n = vecs[i].clear_n;
      run     = vecs[i].run;
      load    = vecs[i].load;
      load_hh = vecs[i].lh;
      load_mm = vecs[i].lm;
      load_ss = vecs[i].ls;
      for (int c = 0; c < vecs[i].cycles; c++) step();
      checks++;
      if ({hh, mm, ss, sec_tick, day_tick, load_err} !==
          {vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].est, vecs[i].edt, vecs[i].eerr}) begin
        errors++;
        $display("FAIL vec%0d got %h:%h:%h st=%b dt=%b err=%b want %h:%h:%h st=%b dt=%b err=%b",
                 i, hh, mm, ss, sec_tick, day_tick, load_err, vecs[i].eh, vecs[i].em,
                 vecs[i].es, vecs[i].est, vecs[i].edt, vecs[i].eerr);
      end
    end

    // randomized run, including loads near midnight so rollovers occur
    for (int n = 0; n < 4000; n++) begin
      clear_n = ($urandom_range(0, 199) != 0);
      run     = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        load_hh = to_bcd(($urandom_range(0, 3) == 0) ? 23 : int'($urandom_range(0, 23)));
        load_mm = to_bcd(($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 59)));
        load_ss = to_bcd(int'($urandom_range(50, 59)));
      end else begin
        load_hh = 8'($urandom);
        load_mm = 8'($urandom);
        load_ss = 8'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
